// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared constants, FSM encoding and pixel packing for the camera capture block
package cam_pkg;

  localparam int IMG_W      = 160;
  localparam int IMG_H      = 120;
  localparam int FRAME_SIZE = IMG_W * IMG_H;
  localparam int MAX_ADDR   = FRAME_SIZE - 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    BYTE1      = 3'd2,
    BYTE2      = 3'd3
  } state_t;

  // RGB565 arrives high byte first; keep the top 4 bits of each colour channel.
  function automatic logic [11:0] rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with rising-edge detect for a camera control line
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;

  // Two metastability stages plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~prev;

endmodule

// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - OV-style RGB565 camera capture into an RGB444 frame buffer
module cam_capture
  import cam_pkg::*;
#(
  parameter int IMG_W = cam_pkg::IMG_W,
  parameter int IMG_H = cam_pkg::IMG_H,
  parameter int AW    = 15,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_PCLK,
  input  logic          CAM_HREF,
  input  logic          CAM_VSYNC,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          DP_RAM_regW,
  output logic          frame_done,
  output logic [2:0]    state
);

  // Writes are allowed only while the address is below one full frame.
  localparam logic [AW-1:0] ADDR_LIMIT = AW'(IMG_W * IMG_H);

  logic       pclk_sync;
  logic       pclk_rise;
  logic       vsync_sync;
  logic       vsync_rise;
  logic       href_s1;
  logic       href_s2;
  logic [7:0] data_s1;
  logic [7:0] data_s2;
  logic [7:0] byte1;
  state_t     cur;

  sync_edge u_sync_pclk (
    .clk  (clk),
    .rst  (rst),
    .din  (CAM_PCLK),
    .sync (pclk_sync),
    .rise (pclk_rise)
  );

  sync_edge u_sync_vsync (
    .clk  (clk),
    .rst  (rst),
    .din  (CAM_VSYNC),
    .sync (vsync_sync),
    .rise (vsync_rise)
  );

  // HREF and data take the same two-stage path so they line up with the PCLK edge
  always_ff @(posedge clk) begin
    if (rst) begin
      href_s1 <= 1'b0;
      href_s2 <= 1'b0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      href_s1 <= CAM_HREF;
      href_s2 <= href_s1;
      data_s1 <= CAM_px_data;
      data_s2 <= data_s1;
    end
  end

  // Capture FSM: frame sync, byte pairing, write strobe and saturating address
  always_ff @(posedge clk) begin
    if (rst) begin
      cur            <= IDLE;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      DP_RAM_regW    <= 1'b0;
      frame_done     <= 1'b0;
      byte1          <= '0;
    end else begin
      DP_RAM_regW <= 1'b0;
      frame_done  <= 1'b0;

      // Address advances the cycle after the write strobe; a frame clear below takes precedence.
      if (DP_RAM_regW && (DP_RAM_addr_in < ADDR_LIMIT)) begin
        DP_RAM_addr_in <= DP_RAM_addr_in + 1'b1;
      end

      case (cur)
        IDLE: begin
          if (vsync_sync) begin
            cur <= WAIT_FRAME;
          end
        end

        WAIT_FRAME: begin
          if (!vsync_sync) begin
            DP_RAM_addr_in <= '0;
            cur            <= BYTE1;
          end
        end

        BYTE1: begin
          if (vsync_rise) begin
            frame_done <= 1'b1;
            cur        <= WAIT_FRAME;
          end else if (pclk_rise && href_s2) begin
            byte1 <= data_s2;
            cur   <= BYTE2;
          end
        end

        BYTE2: begin
          // A completed pixel is written even if the frame ends in the same cycle.
          if (pclk_rise && href_s2 && (DP_RAM_addr_in < ADDR_LIMIT)) begin
            DP_RAM_data_in <= DW'(rgb565_to_444(byte1, data_s2));
            DP_RAM_regW    <= 1'b1;
          end
          if (vsync_rise) begin
            frame_done <= 1'b1;
            cur        <= WAIT_FRAME;
          end else if (pclk_rise) begin
            // HREF low at this edge drops the half pixel so the next line starts aligned.
            cur <= BYTE1;
          end
        end

        default: cur <= IDLE;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_cam_capture.sv
// tb/tb_cam_capture.sv - directed self-checking bench for cam_capture
module tb_cam_capture;
  import cam_pkg::*;

  localparam int TW = 40;
  localparam int TH = 30;
  localparam int AW = 15;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          pclk;
  logic          href;
  logic          vsync;
  logic [7:0]    pxd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          regw;
  logic          fdone;
  logic [2:0]    st;

  cam_capture #(.IMG_W(TW), .IMG_H(TH), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .CAM_PCLK       (pclk),
    .CAM_HREF       (href),
    .CAM_VSYNC      (vsync),
    .CAM_px_data    (pxd),
    .DP_RAM_addr_in (addr),
    .DP_RAM_data_in (wdata),
    .DP_RAM_regW    (regw),
    .frame_done     (fdone),
    .state          (st)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation only; all comparisons happen in the main initial block.
  int   wr_cnt = 0;
  int   fd_cnt = 0;
  int   seq_err = 0;
  int   inc_err = 0;
  int   dbl_err = 0;
  int   last_addr = -1;
  int   last_data = -1;
  int   frame_base = 0;
  logic prev_regw = 1'b0;
  logic prev_fd = 1'b0;
  int   prev_addr = 0;

  always @(negedge clk) begin
    if (regw) begin
      if (int'(addr) != wr_cnt - frame_base) seq_err++;
      if (prev_regw) dbl_err++;
      wr_cnt++;
      last_addr = int'(addr);
      last_data = int'(wdata);
    end
    if (prev_regw && !rst && int'(addr) != prev_addr + 1) inc_err++;
    if (fdone) begin
      fd_cnt++;
      if (prev_fd) dbl_err++;
    end
    prev_regw = regw;
    prev_fd   = fdone;
    prev_addr = int'(addr);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int pix(input int a, input int b);
    return ((a >> 4) << 8) | ((a & 7) << 5) | (((b >> 7) & 1) << 4) | ((b >> 1) & 15);
  endfunction

  function automatic int bval(input int l, input int k);
    return (l * 7 + k * 13) & 255;
  endfunction

  // One camera byte: PCLK low for two clk cycles with data set up, then high for two.
  task automatic cam_byte(input logic h, input logic [7:0] d);
    @(negedge clk);
    pclk = 1'b0;
    href = h;
    pxd  = d;
    @(negedge clk);
    @(negedge clk);
    pclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_bytes(input int n);
    for (int i = 0; i < n; i++) cam_byte(1'b0, 8'h00);
  endtask

  task automatic start_frame();
    vsync = 1'b1;
    idle_bytes(4);
    vsync = 1'b0;
    idle_bytes(4);
    frame_base = wr_cnt;
  endtask

  task automatic end_frame();
    vsync = 1'b1;
    idle_bytes(3);
  endtask

  task automatic send_line(input int nbytes, input int l);
    for (int k = 0; k < nbytes; k++) cam_byte(1'b1, 8'(bval(l, k)));
    idle_bytes(8);
  endtask

  typedef struct {
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   base;
  int   fd0;
  int   saved;

  initial begin
    vecs[0] = '{8'hF0, 8'h0F, 12'hF07};
    vecs[1] = '{8'h0F, 8'hF0, 12'h0F8};
    vecs[2] = '{8'hFF, 8'hFF, 12'hFFF};
    vecs[3] = '{8'hA5, 8'h5A, 12'hAAD};
    vecs[4] = '{8'h12, 8'h34, 12'h14A};
    vecs[5] = '{8'h08, 8'h80, 12'h010};

    rst = 1'b1; pclk = 1'b0; href = 1'b0; vsync = 1'b0; pxd = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", int'(st), int'(IDLE));
    check("reset_addr", int'(addr), 0);
    check("reset_data", int'(wdata), 0);
    check("reset_regw", int'(regw), 0);
    check("reset_frame_done", int'(fdone), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_hold", int'(st), int'(IDLE));

    // Table frame: one pixel per vector, checked as it lands
    start_frame();
    check("frame_start_state", int'(st), int'(BYTE1));
    for (int i = 0; i < 6; i++) begin
      cam_byte(1'b1, vecs[i].b1);
      repeat (4) @(negedge clk);
      check("after_byte1_state", int'(st), int'(BYTE2));
      cam_byte(1'b1, vecs[i].b2);
      idle_bytes(2);
      check("vec_data", last_data, int'(vecs[i].exp));
      check("vec_addr", last_addr, i);
      check("vec_writes", wr_cnt - frame_base, i + 1);
    end
    check("regw_single_cycle", dbl_err, 0);
    check("addr_inc_after_write", inc_err, 0);
    end_frame();
    check("table_frame_done", fd_cnt, 1);
    check("table_end_state", int'(st), int'(WAIT_FRAME));

    // Frame ends with a pending byte1: no write, byte discarded
    start_frame();
    base = wr_cnt;
    cam_byte(1'b1, 8'hAB);
    end_frame();
    check("pending_frame_done", fd_cnt, 2);
    check("pending_no_write", wr_cnt - base, 0);
    check("pending_state", int'(st), int'(WAIT_FRAME));
    start_frame();
    cam_byte(1'b1, 8'hF0);
    cam_byte(1'b1, 8'h0F);
    idle_bytes(2);
    check("after_discard_data", last_data, 'hF07);
    check("after_discard_addr", last_addr, 0);

    // VSYNC rise in the same edge as byte2: pixel still written
    cam_byte(1'b1, 8'h12);
    @(negedge clk);
    pclk = 1'b0; href = 1'b1; pxd = 8'h34;
    @(negedge clk);
    @(negedge clk);
    pclk = 1'b1; vsync = 1'b1;
    @(negedge clk);
    idle_bytes(3);
    check("coincident_data", last_data, 'h14A);
    check("coincident_addr", last_addr, 1);
    check("coincident_frame_done", fd_cnt, 3);
    check("coincident_state", int'(st), int'(WAIT_FRAME));

    // Full frame
    fd0 = fd_cnt;
    start_frame();
    for (int l = 0; l < TH; l++) send_line(2 * TW, l);
    end_frame();
    check("full_writes", wr_cnt - frame_base, TW * TH);
    check("full_last_addr", last_addr, TW * TH - 1);
    check("full_last_data", last_data, pix(bval(TH - 1, 2 * TW - 2), bval(TH - 1, 2 * TW - 1)));
    check("full_frame_done", fd_cnt - fd0, 1);

    // Odd-length line: trailing byte dropped, next line still aligned
    start_frame();
    send_line(2 * TW + 1, 0);
    check("long_line_writes", wr_cnt - frame_base, TW);
    send_line(2 * TW, 1);
    check("next_line_writes", wr_cnt - frame_base, 2 * TW);
    check("next_line_data", last_data, pix(bval(1, 2 * TW - 2), bval(1, 2 * TW - 1)));
    end_frame();

    // Oversized frame: writes stop at the last address, no wrap
    start_frame();
    for (int l = 0; l <= TH; l++) send_line(2 * TW, l);
    check("sat_writes", wr_cnt - frame_base, TW * TH);
    check("sat_last_addr", last_addr, TW * TH - 1);
    check("sat_addr_hold", int'(addr), TW * TH);
    end_frame();

    // Reset mid-line aborts capture until a fresh VSYNC high/low
    start_frame();
    for (int l = 0; l < 10; l++) send_line(2 * TW, l);
    for (int k = 0; k < 40; k++) cam_byte(1'b1, 8'(bval(10, k)));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_state", int'(st), int'(IDLE));
    check("rst_mid_addr", int'(addr), 0);
    check("rst_mid_data", int'(wdata), 0);
    check("rst_mid_regw", int'(regw), 0);
    check("rst_mid_frame_done", int'(fdone), 0);
    rst = 1'b0;
    saved = wr_cnt;
    for (int k = 40; k < 2 * TW; k++) cam_byte(1'b1, 8'(bval(10, k)));
    idle_bytes(8);
    send_line(2 * TW, 11);
    check("rst_no_writes", wr_cnt - saved, 0);
    start_frame();
    cam_byte(1'b1, 8'h0F);
    cam_byte(1'b1, 8'hF0);
    cam_byte(1'b1, 8'hFF);
    cam_byte(1'b1, 8'hFF);
    idle_bytes(2);
    check("restart_writes", wr_cnt - frame_base, 2);
    check("restart_last_addr", last_addr, 1);
    check("restart_data", last_data, 'hFFF);
    check("addr_sequence", seq_err, 0);
    check("regw_pulse_final", dbl_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
